// File: rtl/jedro_1_dmem_arbiter.sv
// rtl/jedro_1_dmem_arbiter.sv - two-master arbiter in front of a single data-RAM slave port
module jedro_1_dmem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ARB_MODE       = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [DATA_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_we_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic                    m0_stb_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic [DATA_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic                    m1_stb_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH/8-1:0] s_we_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    output logic                    s_stb_o,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i
);
    localparam int WE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    // GRANT is the single cycle s_stb_o is high; BUSY waits for the slave
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [1:0]                 stb;
    logic [1:0][DATA_WIDTH-1:0] in_addr;
    logic [1:0][WE_W-1:0]       in_we;
    logic [1:0][DATA_WIDTH-1:0] in_wdata;

    logic [1:0]                 pend;
    logic [1:0][DATA_WIDTH-1:0] req_addr;
    logic [1:0][WE_W-1:0]       req_we;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;

    logic [1:0] in_flight;
    logic [1:0] accept;
    logic [1:0] clr;
    logic [1:0] gnt_vec;

    logic             gnt;
    logic             last_grant;
    logic             winner;
    logic             launch;
    logic             done_ok;
    logic             done_err;
    logic [CNT_W-1:0] cnt;

    logic [DATA_WIDTH-1:0]      s_addr_q;
    logic [WE_W-1:0]            s_we_q;
    logic [DATA_WIDTH-1:0]      s_wdata_q;
    logic [1:0]                 ack_q;
    logic [1:0]                 err_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_q;

    // a master may only hold one request: new strobes are dropped while pending or in flight
    always_comb begin
        stb       = {m1_stb_i, m0_stb_i};
        in_addr   = {m1_addr_i, m0_addr_i};
        in_we     = {m1_we_i, m0_we_i};
        in_wdata  = {m1_wdata_i, m0_wdata_i};
        gnt_vec   = gnt ? 2'b10 : 2'b01;
        in_flight = (state != IDLE) ? gnt_vec : 2'b00;
        accept    = stb & ~pend & ~in_flight;
        clr       = launch ? (winner ? 2'b10 : 2'b01) : 2'b00;
    end

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // arbitration and response decode; slave error outranks ack, both outrank the timeout
    always_comb begin
        state_n  = state;
        launch   = 1'b0;
        winner   = 1'b0;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    launch  = 1'b1;
                    state_n = GRANT;
                    if (pend == 2'b11) begin
                        winner = (ARB_MODE == 1) ? ~last_grant : 1'b0;
                    end else begin
                        winner = pend[1];
                    end
                end
            end
            GRANT, BUSY: begin
                if (s_err_i) begin
                    done_err = 1'b1;
                    state_n  = IDLE;
                end else if (s_ack_i) begin
                    done_ok = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CNT_MAX) begin
                    done_err = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n = BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // per-master request capture; pend is cleared when that master launches
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend      <= '0;
            req_addr  <= '0;
            req_we    <= '0;
            req_wdata <= '0;
        end else begin
            pend <= (pend & ~clr) | accept;
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    req_addr[i]  <= in_addr[i];
                    req_we[i]    <= in_we[i];
                    req_wdata[i] <= in_wdata[i];
                end
            end
        end
    end

    // slave request launch, grant bookkeeping and response timeout counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            s_addr_q   <= '0;
            s_we_q     <= '0;
            s_wdata_q  <= '0;
        end else if (launch) begin
            gnt        <= winner;
            last_grant <= winner;
            cnt        <= '0;
            s_addr_q   <= req_addr[winner];
            s_we_q     <= req_we[winner];
            s_wdata_q  <= req_wdata[winner];
        end else if (state != IDLE && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // one-cycle response pulses steered to the granted master; rdata holds otherwise
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            if (done_ok) begin
                ack_q        <= gnt_vec;
                rdata_q[gnt] <= s_rdata_i;
            end
            if (done_err) begin
                err_q <= gnt_vec;
                if (s_err_i) begin
                    rdata_q[gnt] <= '0;
                end
            end
        end
    end

    assign s_stb_o    = (state == GRANT);
    assign s_addr_o   = s_addr_q;
    assign s_we_o     = s_stb_o ? s_we_q : '0;
    assign s_wdata_o  = s_wdata_q;
    assign m0_ack_o   = ack_q[0];
    assign m0_err_o   = err_q[0];
    assign m0_rdata_o = rdata_q[0];
    assign m1_ack_o   = ack_q[1];
    assign m1_err_o   = err_q[1];
    assign m1_rdata_o = rdata_q[1];

endmodule
